// File: rtl/npc_pkg.sv
// npc_pkg: shared core widths and execute-stage buffer depth.
package npc_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int RB_DEPTH   = 2;
endpackage

// File: rtl/exu_fwd_cmp.sv
// exu_fwd_cmp: one forwarding lookup port over the two buffer entries, youngest match wins.
module exu_fwd_cmp
    import npc_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic [REG_ADDR_W-1:0]       q,
    input  logic [1:0]                  ev,
    input  logic [1:0][REG_ADDR_W-1:0]  rd,
    input  logic [1:0][N-1:0]           res,
    input  logic                        yi,
    output logic                        hit,
    output logic [N-1:0]                data
);
    logic [1:0] m;
    assign m[0] = ev[0] && (rd[0] == q);
    assign m[1] = ev[1] && (rd[1] == q);
    assign hit  = |m;
    assign data = m[yi] ? res[yi] : m[~yi] ? res[~yi] : '0;
endmodule

// File: rtl/exu_result_buf.sv
// exu_result_buf: 2-entry ALU result FIFO toward writeback with rs1/rs2 forwarding lookup.
module exu_result_buf
    import npc_pkg::*;
#(
    parameter int N     = XLEN,
    parameter int DEPTH = RB_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_res,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [N-1:0]          in_pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_res,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wen,
    output logic [N-1:0]          out_pc,
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    output logic                  q_hit1,
    output logic                  q_hit2,
    output logic [N-1:0]          q_data1,
    output logic [N-1:0]          q_data2
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [CW-1:0]                 count;
    logic                          rptr, wptr;
    logic [1:0][N-1:0]             res_q, pc_q;
    logic [1:0][REG_ADDR_W-1:0]    rd_q;
    logic [1:0]                    wen_q, ev;
    logic                          acc, push, pop;
    assign in_ready  = count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign acc       = in_valid && in_ready;
    assign push      = acc && !flush;
    assign pop       = out_valid && out_ready;
    assign out_res   = res_q[rptr];
    assign out_rd    = rd_q[rptr];
    assign out_pc    = pc_q[rptr];
    assign out_wen   = out_valid && wen_q[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
        end else if (flush) begin
            count <= '0;
            rptr  <= 1'b0;
            wptr  <= 1'b0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
        end
    end
    // payload is not reset; validity comes only from count
    always_ff @(posedge clk) begin
        if (push) begin
            res_q[wptr] <= in_res;
            rd_q[wptr]  <= in_rd;
            wen_q[wptr] <= in_wen && (in_rd != '0);
            pc_q[wptr]  <= in_pc;
        end
    end
    assign ev = wen_q & ((count == CW'(2)) ? 2'b11 : (count == CW'(1)) ? (rptr ? 2'b10 : 2'b01) : 2'b00);
    exu_fwd_cmp #(.N(N)) u_cmp1 (.q(q_rs1), .ev(ev), .rd(rd_q), .res(res_q), .yi(~rptr), .hit(q_hit1), .data(q_data1));
    exu_fwd_cmp #(.N(N)) u_cmp2 (.q(q_rs2), .ev(ev), .rd(rd_q), .res(res_q), .yi(~rptr), .hit(q_hit2), .data(q_data2));
endmodule
